// File: rtl/reaction_time_display.sv
// Converts a binary reaction time (ms) into four active-low 7-segment digits using
// an iterative double-dabble converter, and can also show the "dis" pattern.
module reaction_time_display #(
    parameter int BIN_W    = 14,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_value,
    input  logic             in_dq,
    output logic             done,
    output logic             ovf,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state;
    state_t           state_next;
    logic [BIN_W-1:0] shreg;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_next;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pending;
    logic             accept;
    logic             last_step;
    logic             over_max;
    logic             blank3;
    logic             blank2;
    logic             blank1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign over_max  = 32'(in_value) > 32'd9999;
    assign last_step = (state == CONV) && (cnt == CNT_W'(BIN_W - 1));

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = (bcd_adj << 1) | {15'd0, shreg[BIN_W-1]};
    end

    assign blank3 = BLANK_LZ && (bcd_next[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd_next[11:8] == 4'd0);
    assign blank1 = blank2 && (bcd_next[7:4] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !in_dq) state_next = CONV;
            CONV:    if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the display registers only change on a "dis" request or a finished conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            hex0        <= SEG_BLANK;
            hex1        <= SEG_BLANK;
            hex2        <= SEG_BLANK;
            hex3        <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_dq) begin
                        hex3 <= SEG_BLANK;
                        hex2 <= 7'b0100001;
                        hex1 <= 7'b1111011;
                        hex0 <= 7'b0010010;
                        ovf  <= 1'b0;
                        done <= 1'b1;
                    end else if (accept) begin
                        shreg       <= over_max ? BIN_W'(9999) : in_value;
                        bcd         <= '0;
                        cnt         <= '0;
                        ovf_pending <= over_max;
                    end
                end
                CONV: begin
                    shreg <= shreg << 1;
                    bcd   <= bcd_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        hex0 <= seg7(bcd_next[3:0]);
                        hex1 <= blank1 ? SEG_BLANK : seg7(bcd_next[7:4]);
                        hex2 <= blank2 ? SEG_BLANK : seg7(bcd_next[11:8]);
                        hex3 <= blank3 ? SEG_BLANK : seg7(bcd_next[15:12]);
                        ovf  <= ovf_pending;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_time_display.sv
// Scoreboard bench for reaction_time_display: a driver pushes expected displays,
// a monitor pops and compares them whenever done pulses.
module tb_reaction_time_display;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [BIN_W-1:0] in_value;
    logic             in_dq;
    logic             in_ready, done, ovf;
    logic [6:0]       hex0, hex1, hex2, hex3;
    logic             in_ready_n, done_n, ovf_n;
    logic [6:0]       hex0_n, hex1_n, hex2_n, hex3_n;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit prev_done = 1'b0;

    typedef struct {
        int value;
        bit dq;
        int due;
    } exp_t;
    exp_t sb[$];

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    reaction_time_display #(.BIN_W(BIN_W), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_dq(in_dq), .done(done), .ovf(ovf),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    reaction_time_display #(.BIN_W(BIN_W), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_value(in_value), .in_dq(in_dq), .done(done_n), .ovf(ovf_n),
        .hex0(hex0_n), .hex1(hex1_n), .hex2(hex2_n), .hex3(hex3_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference display: decimal digits of the saturated value, blanking by magnitude.
    function automatic logic [27:0] model_hex(input int v, input bit dq, input bit lz);
        int s;
        logic [6:0] h0, h1, h2, h3;
        if (dq) return {7'h7F, 7'b0100001, 7'b1111011, 7'b0010010};
        s  = (v > 9999) ? 9999 : v;
        h0 = SEG[s % 10];
        h1 = (lz && s < 10)   ? 7'h7F : SEG[(s / 10) % 10];
        h2 = (lz && s < 100)  ? 7'h7F : SEG[(s / 100) % 10];
        h3 = (lz && s < 1000) ? 7'h7F : SEG[(s / 1000) % 10];
        return {h3, h2, h1, h0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                checkOutput("done_single", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("done_latency", cyc, e.due);
                    checkOutput("hex_lz", {4'd0, hex3, hex2, hex1, hex0},
                                {4'd0, model_hex(e.value, e.dq, 1'b1)});
                    checkOutput("ovf", 32'(ovf), 32'((!e.dq) && (e.value > 9999)));
                    checkOutput("nolz_done", 32'(done_n), 32'd1);
                    checkOutput("hex_nolz", {4'd0, hex3_n, hex2_n, hex1_n, hex0_n},
                                {4'd0, model_hex(e.value, e.dq, 1'b0)});
                end
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                checkOutput("done_latency", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            prev_done = done;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input int v, input bit dq, input bit inject);
        int lowcnt = 0;
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_value = BIN_W'(v);
        in_dq    = dq;
        sb.push_back('{value: v, dq: dq, due: cyc + 1 + (dq ? 0 : BIN_W)});
        @(negedge clk);
        in_valid = 1'b0;
        while (!in_ready && lowcnt < 100) begin
            in_valid = inject && (lowcnt == 2);
            if (in_valid) begin
                in_value = BIN_W'(800);
                in_dq    = 1'b0;
            end
            @(negedge clk);
            lowcnt++;
        end
        in_valid = 1'b0;
        checkOutput("ready_low_cycles", lowcnt, dq ? 0 : BIN_W);
    endtask

    initial begin
        int dir_vals [17] = '{237, 0, 42, 12000, 5, 123, 1500, 9999, 10000, 16383,
                              1, 9, 10, 99, 100, 999, 1000};
        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        in_dq    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_hex", {4'd0, hex3, hex2, hex1, hex0}, 32'h0FFFFFFF);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);

        foreach (dir_vals[i]) begin
            applyStimulus(dir_vals[i], dir_vals[i] == 123, dir_vals[i] == 1500);
        end
        applyStimulus(77, 1'b1, 1'b0);
        applyStimulus(12000, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Abort a conversion of 999 seven cycles in; no done pulse may follow.
        wait_ready();
        in_valid = 1'b1;
        in_value = BIN_W'(999);
        in_dq    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_hex", {4'd0, hex3, hex2, hex1, hex0}, 32'h0FFFFFFF);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("abort_hex_hold", {4'd0, hex3, hex2, hex1, hex0}, 32'h0FFFFFFF);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, 16383)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0);
        end

        repeat (30) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
